// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and widths for the multiply/divide unit
package mdu_pkg;
    localparam int DIV_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 iteration, compare/subtract carried at W+1 bits
module div_step
    import mdu_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] q_o
);
    logic [W:0] sh;
    logic [W:0] diff;
    logic       ge;
    // shift next dividend bit into the partial remainder, subtract when it fits
    always_comb begin
        sh    = {rem_i, q_i[W-1]};
        diff  = sh - {1'b0, d_i};
        ge    = ~diff[W];
        rem_o = ge ? diff[W-1:0] : sh[W-1:0];
        q_o   = {q_i[W-2:0], ge};
    end
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider (div/divu), quotient to LO, remainder to HI
module div_iter
    import mdu_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         signed_i,
    input  logic [W-1:0] dividend_i32,
    input  logic [W-1:0] divisor_i32,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quot_o32,
    output logic [W-1:0] rem_o32
);
    localparam int CW = $clog2(W) + 1;
    div_state_t    state_q, state_d;
    logic [W-1:0]  rem_w_q, q_w_q, d_q, quot_q, rem_q;
    logic [W-1:0]  step_rem, step_q, a_mag, b_mag;
    logic [CW-1:0] cnt_q;
    logic          neg_quot_q, neg_rem_q, div0_q, accept, last;
    assign accept = start_i && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CW'(W - 1));
    assign a_mag  = (signed_i && dividend_i32[W-1]) ? -dividend_i32 : dividend_i32;
    assign b_mag  = (signed_i && divisor_i32[W-1]) ? -divisor_i32 : divisor_i32;
    assign quot_o32 = quot_q;
    assign rem_o32  = rem_q;
    div_step #(.W(W)) u_step (
        .rem_i (rem_w_q),
        .q_i   (q_w_q),
        .d_i   (d_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );
    // state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // next-state: start only honoured outside RUN, RUN ends after W iterations
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // outputs decoded from state
    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end
    // working registers iterate; visible results only change on the last iteration
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_w_q    <= '0;
            q_w_q      <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else if (accept) begin
            rem_w_q    <= '0;
            q_w_q      <= a_mag;
            d_q        <= b_mag;
            cnt_q      <= '0;
            neg_quot_q <= signed_i & (dividend_i32[W-1] ^ divisor_i32[W-1]);
            neg_rem_q  <= signed_i & dividend_i32[W-1];
            div0_q     <= (divisor_i32 == '0);
        end else if (state_q == RUN) begin
            rem_w_q <= step_rem;
            q_w_q   <= step_q;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                // divide by zero leaves q all ones and rem = |a|; re-signing rem restores the dividend
                quot_q <= div0_q ? '1 : (neg_quot_q ? -step_q : step_q);
                rem_q  <= neg_rem_q ? -step_rem : step_rem;
            end
        end
    end
endmodule
